// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_LZS    = 2'd1,
    MODE_SCROLL = 2'd2
  } mode_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reserved encoding 3 falls back to direct display.
  function automatic mode_e to_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_LZS;
      2'd2:    return MODE_SCROLL;
      default: return MODE_DIRECT;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_display_ctrl.sv
// NUM_DIGITS seven-segment driver with blink, leading-zero suppress and scroll.
// Define SEG7_DP_EN to add the wr_dp / dp_out decimal-point ports.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50000000,
  parameter int BLINK_HZ   = 2,
  parameter int SCROLL_HZ  = 4
) (
  input  logic                      clk_50,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  input  logic [NUM_DIGITS-1:0]     wr_blink,
  input  logic [1:0]                wr_mode,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]     wr_dp,
  output logic [NUM_DIGITS-1:0]     dp_out,
`endif
  output logic [7*NUM_DIGITS-1:0]   seg_out
);

  localparam int BLINK_TC  = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int SCROLL_TC = CLK_HZ / SCROLL_HZ - 1;
  localparam int BW        = $clog2(BLINK_TC) + 1;
  localparam int SW        = $clog2(SCROLL_TC) + 1;
  localparam int OW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [BW-1:0] BLINK_END  = BW'(BLINK_TC);
  localparam logic [SW-1:0] SCROLL_END = SW'(SCROLL_TC);
  localparam logic [OW-1:0] OFF_LAST   = OW'(NUM_DIGITS - 1);

  if (BLINK_TC < 1) begin : g_bad_blink
    $error("seg7_display_ctrl: blink terminal count must be >= 1");
  end
  if (SCROLL_TC < 1) begin : g_bad_scroll
    $error("seg7_display_ctrl: scroll terminal count must be >= 1");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_display_ctrl: NUM_DIGITS must be 1..8");
  end

  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  mode_e                   mode_q, mode_d;
  logic                    loaded_q, loaded_d;
  logic                    commit_q, commit_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    bphase_q, bphase_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  logic [OW-1:0]           soff_q, soff_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dpo_q, dpo_d;
`endif

  logic                    accept;
  logic [3:0]              nib_sel [NUM_DIGITS];
  logic [6:0]              dec_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   blink_blank;
  logic                    lead;
  int                      src;

  // The cycle after an accept is the commit cycle; no new write is taken then.
  assign wr_ready = ~commit_q;
  assign accept   = wr_valid & ~commit_q;
  assign seg_out  = seg_q;
`ifdef SEG7_DP_EN
  assign dp_out   = dpo_q;
`endif

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    mode_d   = mode_q;
    loaded_d = loaded_q;
    commit_d = accept;
`ifdef SEG7_DP_EN
    dp_d     = dp_q;
`endif
    if (accept) begin
      data_d   = wr_data;
      blink_d  = wr_blink;
      mode_d   = to_mode(wr_mode);
      loaded_d = 1'b1;
`ifdef SEG7_DP_EN
      dp_d     = wr_dp;
`endif
    end
  end

  always_comb begin
    bcnt_d   = bcnt_q + 1'b1;
    bphase_d = bphase_q;
    if (accept) begin
      bcnt_d   = '0;
      bphase_d = 1'b0;
    end else if (bcnt_q == BLINK_END) begin
      bcnt_d   = '0;
      bphase_d = ~bphase_q;
    end
  end

  // Scroll position only advances in scroll mode and restarts on every write.
  always_comb begin
    scnt_d = scnt_q + 1'b1;
    soff_d = soff_q;
    if (accept || mode_q != MODE_SCROLL) begin
      scnt_d = '0;
      soff_d = '0;
    end else if (scnt_q == SCROLL_END) begin
      scnt_d = '0;
      soff_d = (soff_q == OFF_LAST) ? '0 : soff_q + 1'b1;
    end
  end

  always_comb begin
    src = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      src = i - int'(soff_q);
      if (src < 0) src = src + NUM_DIGITS;
      nib_sel[i] = data_q[4*src +: 4];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .nibble (nib_sel[g]),
      .seg    (dec_seg[g])
    );
  end

  // Walk down from the leftmost digit; digit 0 always stays visible.
  always_comb begin
    lead     = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && data_q[4*i +: 4] == 4'd0) lz_blank[i] = 1'b1;
      else lead = 1'b0;
    end
    if (mode_q != MODE_LZS) lz_blank = '0;
  end

  always_comb begin
    blink_blank = blink_q & {NUM_DIGITS{bphase_q}};
    seg_d       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!loaded_q || blink_blank[i] || lz_blank[i]) seg_d[7*i +: 7] = SEG_OFF;
      else seg_d[7*i +: 7] = dec_seg[i];
    end
`ifdef SEG7_DP_EN
    dpo_d = ~(dp_q & ~blink_blank & {NUM_DIGITS{loaded_q}});
`endif
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      data_q   <= '0;
      blink_q  <= '0;
      mode_q   <= MODE_DIRECT;
      loaded_q <= 1'b0;
      commit_q <= 1'b0;
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
      scnt_q   <= '0;
      soff_q   <= '0;
      seg_q    <= {NUM_DIGITS{SEG_OFF}};
`ifdef SEG7_DP_EN
      dp_q     <= '0;
      dpo_q    <= '1;
`endif
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      mode_q   <= mode_d;
      loaded_q <= loaded_d;
      commit_q <= commit_d;
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      scnt_q   <= scnt_d;
      soff_q   <= soff_d;
      seg_q    <= seg_d;
`ifdef SEG7_DP_EN
      dp_q     <= dp_d;
      dpo_q    <= dpo_d;
`endif
    end
  end

endmodule
